// File: rtl/dm9000_bus_ctrl_if.sv
// Bundle of the user request/response handshake and the DM9000A host-bus pins.
// Handshake: a request is accepted on a rising clk edge where req_valid && req_ready.
// After that edge the request inputs are ignored until req_ready returns high.
// rsp_valid pulses for one cycle per completed request.
interface dm9000_bus_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_reg;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        eth_cs;
    logic        eth_cmd;
    logic        eth_ior;
    logic        eth_iow;
    logic [15:0] eth_data_o;
    logic        eth_data_oe;
    logic [15:0] eth_data_i;

    // The user logic plus pad/bus model side.
    modport master (
        output req_valid, req_write, req_reg, req_wdata, eth_data_i,
        input  req_ready, rsp_valid, rsp_rdata,
        input  eth_cs, eth_cmd, eth_ior, eth_iow, eth_data_o, eth_data_oe
    );

    // The register-access engine.
    modport slave (
        input  req_valid, req_write, req_reg, req_wdata, eth_data_i,
        output req_ready, rsp_valid, rsp_rdata,
        output eth_cs, eth_cmd, eth_ior, eth_iow, eth_data_o, eth_data_oe
    );
endinterface

// File: rtl/dm9000_bus_ctrl.sv
// DM9000A register-access engine: one user request becomes an index cycle then a
// data cycle on CS/CMD/IOR/IOW, with every pin driven straight from a flop.
module dm9000_bus_ctrl #(
    parameter int unsigned SETUP   = 1,
    parameter int unsigned PULSE   = 2,
    parameter int unsigned RECOVER = 2
) (
    input  logic              clk,
    input  logic              rst,
    dm9000_bus_ctrl_if.slave  bus,
    output logic [3:0]        dbg_state
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        I_SETUP  = 4'd1,
        I_STROBE = 4'd2,
        I_HOLD   = 4'd3,
        I_REC    = 4'd4,
        D_SETUP  = 4'd5,
        D_STROBE = 4'd6,
        D_HOLD   = 4'd7,
        D_REC    = 4'd8,
        DONE     = 4'd9
    } state_t;

    localparam logic [3:0] SETUP_CNT   = 4'(SETUP - 1);
    localparam logic [3:0] PULSE_CNT   = 4'(PULSE - 1);
    localparam logic [3:0] RECOVER_CNT = 4'(RECOVER - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [7:0]  reg_q, reg_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        ready_q, ready_d;
    logic        cs_q, cs_d;
    logic        cmd_q, cmd_d;
    logic        ior_q, ior_d;
    logic        iow_q, iow_d;
    logic [15:0] dout_q, dout_d;
    logic        oe_q, oe_d;
    logic        last_cycle;

    assign last_cycle = (cnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        reg_d   = reg_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid && ready_q) begin
                    write_d = bus.req_write;
                    reg_d   = bus.req_reg;
                    wdata_d = bus.req_wdata;
                    state_d = I_SETUP;
                    cnt_d   = SETUP_CNT;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                if (!last_cycle) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    unique case (state_q)
                        I_SETUP:  begin state_d = I_STROBE; cnt_d = PULSE_CNT;   end
                        I_STROBE: begin state_d = I_HOLD;   cnt_d = 4'd0;        end
                        I_HOLD:   begin state_d = I_REC;    cnt_d = RECOVER_CNT; end
                        I_REC:    begin state_d = D_SETUP;  cnt_d = SETUP_CNT;   end
                        D_SETUP:  begin state_d = D_STROBE; cnt_d = PULSE_CNT;   end
                        D_STROBE: begin state_d = D_HOLD;   cnt_d = 4'd0;        end
                        D_HOLD:   begin state_d = D_REC;    cnt_d = RECOVER_CNT; end
                        D_REC:    begin state_d = DONE;     cnt_d = 4'd0;        end
                        default:  begin state_d = IDLE;     cnt_d = 4'd0;        end
                    endcase
                end
            end
        endcase

        // IOR is still low on this edge, so the chip is still driving the bus.
        if (state_q == D_STROBE && last_cycle && !write_q) begin
            rdata_d = bus.eth_data_i;
        end

        // Pin values are decoded from the state being entered so they settle with it.
        cs_d        = 1'b1;
        cmd_d       = 1'b1;
        ior_d       = 1'b1;
        iow_d       = 1'b1;
        oe_d        = 1'b0;
        dout_d      = dout_q;
        ready_d     = (state_d == IDLE);
        rsp_valid_d = (state_d == DONE);

        unique case (state_d)
            I_SETUP, I_STROBE, I_HOLD: begin
                cs_d   = 1'b0;
                cmd_d  = 1'b0;
                oe_d   = 1'b1;
                dout_d = {8'h00, reg_d};
                iow_d  = (state_d != I_STROBE);
            end
            D_SETUP, D_STROBE, D_HOLD: begin
                cs_d  = 1'b0;
                cmd_d = 1'b1;
                oe_d  = write_d;
                if (write_d) begin
                    dout_d = wdata_d;
                end
                iow_d = !(write_d && state_d == D_STROBE);
                ior_d = !(!write_d && state_d == D_STROBE);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            write_q     <= 1'b0;
            reg_q       <= 8'h00;
            wdata_q     <= 16'h0000;
            rdata_q     <= 16'h0000;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            cs_q        <= 1'b1;
            cmd_q       <= 1'b1;
            ior_q       <= 1'b1;
            iow_q       <= 1'b1;
            dout_q      <= 16'h0000;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            ready_q     <= ready_d;
            cs_q        <= cs_d;
            cmd_q       <= cmd_d;
            ior_q       <= ior_d;
            iow_q       <= iow_d;
            dout_q      <= dout_d;
            oe_q        <= oe_d;
        end
    end

    assign bus.req_ready   = ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.eth_cs      = cs_q;
    assign bus.eth_cmd     = cmd_q;
    assign bus.eth_ior     = ior_q;
    assign bus.eth_iow     = iow_q;
    assign bus.eth_data_o  = dout_q;
    assign bus.eth_data_oe = oe_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_dm9000_bus_ctrl.sv
// Bench for dm9000_bus_ctrl: default-parameter instance plus a SETUP=2/PULSE=4/RECOVER=1
// instance, checked cycle by cycle against a phase-arithmetic model of the bus waveform.
module tb_dm9000_bus_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_write;
    logic [7:0]  req_reg;
    logic [15:0] req_wdata, bus_val;
    int          sel;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_on = 1'b0;
    logic [3:0]  dbg_a, dbg_b;
    logic [15:0] m_do [2];
    logic [15:0] m_rdata [2];

    dm9000_bus_ctrl_if ifa ();
    dm9000_bus_ctrl_if ifb ();

    dm9000_bus_ctrl u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .bus       (ifa),
        .dbg_state (dbg_a)
    );

    dm9000_bus_ctrl #(.SETUP(2), .PULSE(4), .RECOVER(1)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .bus       (ifb),
        .dbg_state (dbg_b)
    );

    assign ifa.req_valid  = req_valid && (sel == 0);
    assign ifb.req_valid  = req_valid && (sel == 1);
    assign ifa.req_write  = req_write;
    assign ifb.req_write  = req_write;
    assign ifa.req_reg    = req_reg;
    assign ifb.req_reg    = req_reg;
    assign ifa.req_wdata  = req_wdata;
    assign ifb.req_wdata  = req_wdata;
    // The chip drives the value only while IOR is low; the inverse elsewhere exposes mistimed capture.
    assign ifa.eth_data_i = ifa.eth_ior ? ~bus_val : bus_val;
    assign ifb.eth_data_i = ifb.eth_ior ? ~bus_val : bus_val;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        cs;
        logic        cmd;
        logic        ior;
        logic        iow;
        logic        oe;
        logic [15:0] dout;
        logic        rsp;
        logic        rdy;
        logic [15:0] rdata;
    } snap_t;

    localparam snap_t RST_SNAP = '{cs: 1'b1, cmd: 1'b1, ior: 1'b1, iow: 1'b1, oe: 1'b0,
                                   dout: 16'h0000, rsp: 1'b0, rdy: 1'b0, rdata: 16'h0000};

    typedef struct {
        bit          w;
        logic [7:0]  r;
        logic [15:0] wd;
        logic [15:0] bv;
        bit          keep;
        int          exp_gap;
        logic [15:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    function automatic snap_t get_snap();
        snap_t s;
        if (sel == 0)
            s = {ifa.eth_cs, ifa.eth_cmd, ifa.eth_ior, ifa.eth_iow, ifa.eth_data_oe,
                 ifa.eth_data_o, ifa.rsp_valid, ifa.req_ready, ifa.rsp_rdata};
        else
            s = {ifb.eth_cs, ifb.eth_cmd, ifb.eth_ior, ifb.eth_iow, ifb.eth_data_oe,
                 ifb.eth_data_o, ifb.rsp_valid, ifb.req_ready, ifb.rsp_rdata};
        return s;
    endfunction

    function automatic int p_setup();   return (sel == 1) ? 2 : 1; endfunction
    function automatic int p_pulse();   return (sel == 1) ? 4 : 2; endfunction
    function automatic int p_recover(); return (sel == 1) ? 1 : 2; endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Strobes never overlap and never fall while CS is high.
    always @(negedge clk) begin
        if (mon_on && !rst) begin
            check("strobe_rules_a", {ifa.eth_ior | ifa.eth_iow, !ifa.eth_cs | (ifa.eth_ior & ifa.eth_iow)}, 2'b11);
            check("strobe_rules_b", {ifb.eth_ior | ifb.eth_iow, !ifb.eth_cs | (ifb.eth_ior & ifb.eth_iow)}, 2'b11);
        end
    end

    // Called at a negedge with the request fields set; returns the accept cycle number.
    task automatic do_accept(output int acc_cyc);
        snap_t s;
        int n = 0;
        req_valid = 1'b1;
        s = get_snap();
        while (!s.rdy && n < 60) begin
            @(negedge clk);
            s = get_snap();
            n++;
        end
        if (!s.rdy) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
    endtask

    // Follows one accepted transaction to the idle cycle after rsp_valid.
    task automatic track(input bit w, input logic [7:0] r, input logic [15:0] wd,
                         input logic [15:0] bv, input bit keep, output int lat);
        int s_c, p_c, r_c, l_c, t_c, h, o;
        bit strobe;
        snap_t e, a;
        s_c = p_setup();
        p_c = p_pulse();
        r_c = p_recover();
        l_c = s_c + p_c + 1 + r_c;
        t_c = 2 * l_c;
        lat = -1;
        req_valid = keep;
        for (int k = 1; k <= t_c + 2; k++) begin
            req_write = 1'($urandom);
            req_reg   = 8'($urandom);
            req_wdata = 16'($urandom);
            @(negedge clk);
            e = RST_SNAP;
            if (k <= t_c) begin
                h = (k - 1) / l_c;
                o = (k - 1) % l_c;
                if (o < s_c + p_c + 1) begin
                    strobe = (o >= s_c) && (o < s_c + p_c);
                    e.cs   = 1'b0;
                    e.cmd  = (h == 1);
                    if (h == 0) begin
                        m_do[sel] = {8'h00, r};
                        e.oe  = 1'b1;
                        e.iow = !strobe;
                    end else if (w) begin
                        m_do[sel] = wd;
                        e.oe  = 1'b1;
                        e.iow = !strobe;
                    end else begin
                        e.ior = !strobe;
                    end
                end
                if (!w && k == l_c + s_c + p_c + 1) m_rdata[sel] = bv;
            end else if (k == t_c + 1) begin
                e.rsp = 1'b1;
            end else begin
                e.rdy = 1'b1;
            end
            e.dout  = m_do[sel];
            e.rdata = m_rdata[sel];
            a = get_snap();
            check($sformatf("bus_cycle_%0d", k), a, e);
            if (a.rsp && lat < 0) lat = k - 1;
        end
    endtask

    task automatic run_one(input bit w, input logic [7:0] r, input logic [15:0] wd,
                           input logic [15:0] bv, input bit keep, output int acc, output int lat);
        req_write = w;
        req_reg   = r;
        req_wdata = wd;
        bus_val   = bv;
        do_accept(acc);
        track(w, r, wd, bv, keep, lat);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t  vt [5];
        snap_t s;
        int    acc, prev_acc, lat, exp_lat;
        bit    seen, keep, w;
        logic [7:0]  r;
        logic [15:0] wd, bv;

        vt[0] = '{w: 1'b1, r: 8'h1F, wd: 16'h0000, bv: 16'h5555, keep: 1'b0, exp_gap: -1, exp_rdata: 16'h0000, exp_lat: 12};
        vt[1] = '{w: 1'b0, r: 8'h28, wd: 16'h1234, bv: 16'h0A46, keep: 1'b0, exp_gap: -1, exp_rdata: 16'h0A46, exp_lat: 12};
        vt[2] = '{w: 1'b1, r: 8'h05, wd: 16'hBEEF, bv: 16'h7777, keep: 1'b0, exp_gap: -1, exp_rdata: 16'h0A46, exp_lat: 12};
        vt[3] = '{w: 1'b1, r: 8'hFE, wd: 16'h003F, bv: 16'h1111, keep: 1'b1, exp_gap: -1, exp_rdata: 16'h0A46, exp_lat: 12};
        vt[4] = '{w: 1'b0, r: 8'h29, wd: 16'h0000, bv: 16'h0019, keep: 1'b0, exp_gap: 14, exp_rdata: 16'h0019, exp_lat: 12};

        for (int i = 0; i < 2; i++) begin
            m_do[i]    = 16'h0000;
            m_rdata[i] = 16'h0000;
        end
        sel       = 0;
        rst       = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_reg   = 8'h33;
        req_wdata = 16'hA5A5;
        bus_val   = 16'h0000;

        // Reset held for three cycles with a request pending.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_a_%0d", i), get_snap(), RST_SNAP);
        end
        sel = 1;
        check("reset_b", get_snap(), RST_SNAP);
        sel = 0;
        rst = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        s = RST_SNAP;
        s.rdy = 1'b1;
        check("ready_after_reset", get_snap(), s);
        check("no_accept_in_reset", dbg_a, 4'd0);
        req_valid = 1'b0;
        @(negedge clk);
        check("idle_after_reset", get_snap(), s);

        // Directed vectors, including a held-valid back-to-back pair.
        prev_acc = 0;
        for (int i = 0; i < 5; i++) begin
            run_one(vt[i].w, vt[i].r, vt[i].wd, vt[i].bv, vt[i].keep, acc, lat);
            if (vt[i].exp_gap >= 0) check($sformatf("vec%0d_gap", i), acc - prev_acc, vt[i].exp_gap);
            check($sformatf("vec%0d_lat", i), lat, vt[i].exp_lat);
            s = get_snap();
            check($sformatf("vec%0d_rdata", i), s.rdata, vt[i].exp_rdata);
            prev_acc = acc;
        end
        req_valid = 1'b0;

        // Reset during the index strobe of a write.
        req_write = 1'b1;
        req_reg   = 8'h44;
        req_wdata = 16'hCAFE;
        do_accept(acc);
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) @(negedge clk);
        s = get_snap();
        check("mid_in_strobe_iow", s.iow, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            m_do[i]    = 16'h0000;
            m_rdata[i] = 16'h0000;
        end
        check("mid_reset_state", get_snap(), RST_SNAP);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            s = get_snap();
            if (s.rsp || !s.cs) seen = 1'b1;
        end
        check("mid_reset_discarded", seen, 1'b0);
        run_one(1'b0, 8'h10, 16'h0000, 16'h9C3E, 1'b0, acc, lat);
        check("mid_fresh_read_lat", lat, 12);
        s = get_snap();
        check("mid_fresh_read_rdata", s.rdata, 16'h9C3E);

        // Random traffic on the default instance.
        prev_acc = 0;
        keep = 1'b0;
        for (int i = 0; i < 24; i++) begin
            bit prev_keep;
            prev_keep = keep;
            w    = 1'($urandom_range(0, 1));
            r    = 8'($urandom_range(0, 255));
            wd   = 16'($urandom);
            bv   = 16'($urandom);
            keep = (i == 23) ? 1'b0 : 1'($urandom_range(0, 1));
            run_one(w, r, wd, bv, keep, acc, lat);
            if (prev_keep) check($sformatf("rand%0d_gap", i), acc - prev_acc, 14);
            check($sformatf("rand%0d_lat", i), lat, 12);
            prev_acc = acc;
        end
        req_valid = 1'b0;
        @(negedge clk);

        // Parameter variant SETUP=2, PULSE=4, RECOVER=1.
        sel = 1;
        exp_lat = 16;
        run_one(1'b1, 8'h1F, 16'h0000, 16'h0000, 1'b0, acc, lat);
        check("var_write_lat", lat, exp_lat);
        run_one(1'b0, 8'h28, 16'h0000, 16'h0A46, 1'b0, acc, lat);
        check("var_read_lat", lat, exp_lat);
        s = get_snap();
        check("var_read_rdata", s.rdata, 16'h0A46);
        for (int i = 0; i < 4; i++) begin
            run_one(1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom), 16'($urandom), 1'b0, acc, lat);
            check($sformatf("var_rand%0d_lat", i), lat, exp_lat);
        end
        req_valid = 1'b0;
        @(negedge clk);

        mon_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
